wrr_grant_sched: RTL and testbench

WRR_GRANT_SCHED -- requirements
Module: wrr_grant_sched

---
 rtl/wrr_grant_sched.sv | 149 ++++++++++++++
 tb/tb_wrr_grant_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_grant_sched.sv
// Weighted round-robin grant scheduler: one queue at a time holds the grant and may
// send up to its programmed weight in packets before the search moves on.
//
// state   | meaning
// ST_IDLE | searching upward from ptr+1 for the next eligible queue
// ST_BUSY | grant held for the current queue's turn
module wrr_grant_sched #(
    parameter int NUM_QUEUES     = 8,
    parameter int WEIGHT_WIDTH   = 7,
    parameter int DEFAULT_WEIGHT = 1,
    parameter int IDX_W          = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_QUEUES-1:0]   req,
    input  logic                    out_rdy,
    input  logic                    pkt_done,
    input  logic                    wt_wr_en,
    input  logic [IDX_W-1:0]        wt_wr_addr,
    input  logic [WEIGHT_WIDTH-1:0] wt_wr_data,
    input  logic [IDX_W-1:0]        wt_rd_addr,
    output logic [WEIGHT_WIDTH-1:0] wt_rd_data,
    output logic [NUM_QUEUES-1:0]   grant,
    output logic                    grant_valid,
    output logic [IDX_W-1:0]        grant_idx,
    output logic [WEIGHT_WIDTH-1:0] credit
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [WEIGHT_WIDTH-1:0] weight_q [NUM_QUEUES];

    logic [0:0]              state_q,  state_d;
    logic [IDX_W-1:0]        ptr_q,    ptr_d;
    logic [NUM_QUEUES-1:0]   grant_q,  grant_d;
    logic                    valid_q,  valid_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic [NUM_QUEUES-1:0]   elig;
    logic [2*NUM_QUEUES-1:0] elig_dbl;
    logic [NUM_QUEUES-1:0]   elig_rot;
    logic [IDX_W:0]          start;
    logic [IDX_W:0]          off;
    logic [IDX_W:0]          sum;
    logic                    found;
    logic [IDX_W-1:0]        sel_idx;
    logic [WEIGHT_WIDTH-1:0] cred_dec;
    logic                    stay;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            elig[i] = req[i] & (|weight_q[i]);
        end
    end

    // Rotate eligibility so bit 0 is queue ptr+1, then take the lowest set bit.
    always_comb begin
        start = {1'b0, ptr_q} + (IDX_W+1)'(1);
        if (start >= (IDX_W+1)'(NUM_QUEUES)) begin
            start = '0;
        end
        elig_dbl = {elig, elig};
        elig_rot = NUM_QUEUES'(elig_dbl >> start);
        found    = 1'b0;
        off      = '0;
        for (int j = 0; j < NUM_QUEUES; j++) begin
            if (!found && elig_rot[j]) begin
                found = 1'b1;
                off   = (IDX_W+1)'(j);
            end
        end
        sum = start + off;
        if (sum >= (IDX_W+1)'(NUM_QUEUES)) begin
            sum = sum - (IDX_W+1)'(NUM_QUEUES);
        end
        sel_idx = sum[IDX_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        credit_d = credit_q;
        cred_dec = (credit_q == '0) ? '0 : credit_q - WEIGHT_WIDTH'(1);
        stay     = (cred_dec != '0) && req[idx_q] && (|weight_q[idx_q]) && out_rdy;

        if (state_q == ST_IDLE) begin
            if (out_rdy && found) begin
                state_d          = ST_BUSY;
                grant_d          = '0;
                grant_d[sel_idx] = 1'b1;
                valid_d          = 1'b1;
                idx_d            = sel_idx;
                // weight_q still holds the pre-write value if a write lands this edge
                credit_d         = weight_q[sel_idx];
            end
        end else begin
            if (pkt_done) begin
                credit_d = cred_dec;
                if (!stay) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IDX_W'(NUM_QUEUES - 1);
            grant_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            credit_q <= credit_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                weight_q[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
            end
        end else if (wt_wr_en) begin
            weight_q[wt_wr_addr] <= wt_wr_data;
        end
    end

    assign wt_rd_data  = weight_q[wt_rd_addr];
    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_wrr_grant_sched.sv
// Bench for wrr_grant_sched: a turn-level reference model checked every cycle,
// plus directed scenarios with literal expected grants and credits.
module tb_wrr_grant_sched;
    localparam int NQ = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req = '0;
    logic       out_rdy = 1'b0;
    logic       pkt_done = 1'b0;
    logic       wt_wr_en = 1'b0;
    logic [2:0] wt_wr_addr = '0;
    logic [6:0] wt_wr_data = '0;
    logic [2:0] wt_rd_addr = '0;
    logic [6:0] wt_rd_data;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [6:0] credit;

    int n_cmp = 0;
    int n_fail = 0;

    wrr_grant_sched #(.NUM_QUEUES(8), .WEIGHT_WIDTH(7), .DEFAULT_WEIGHT(1)) dut (
        .clk(clk), .reset(reset), .req(req), .out_rdy(out_rdy), .pkt_done(pkt_done),
        .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_data(wt_wr_data),
        .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data), .grant(grant),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .credit(credit)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a turn is (queue, packets left); weights apply at the next turn start.
    bit m_busy;
    int m_q, m_credit, m_ptr, m_c, m_nq;
    int m_w [NQ];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_q = 0; m_credit = 0; m_ptr = NQ - 1;
            for (int i = 0; i < NQ; i++) m_w[i] = 1;
        end else begin
            if (!m_busy) begin
                m_nq = -1;
                if (out_rdy) begin
                    for (int k = 1; k <= NQ; k++) begin
                        if (m_nq < 0 && req[(m_ptr + k) % NQ] && m_w[(m_ptr + k) % NQ] != 0)
                            m_nq = (m_ptr + k) % NQ;
                    end
                end
                if (m_nq >= 0) begin
                    m_busy = 1; m_q = m_nq; m_credit = m_w[m_nq];
                end
            end else if (pkt_done) begin
                m_c = (m_credit > 0) ? m_credit - 1 : 0;
                if (m_c != 0 && req[m_q] && m_w[m_q] != 0 && out_rdy) begin
                    m_credit = m_c;
                end else begin
                    m_busy = 0; m_ptr = m_q; m_credit = m_c;
                end
            end
            if (wt_wr_en) m_w[wt_wr_addr] = int'(wt_wr_data);
        end
    end

    always @(posedge clk) begin
        #1;
        check("mdl grant", 32'(grant), m_busy ? (32'd1 << m_q) : 32'd0);
        check("mdl grant_valid", 32'(grant_valid), 32'(m_busy));
        if (m_busy) begin
            check("mdl grant_idx", 32'(grant_idx), 32'(m_q));
            check("mdl credit", 32'(credit), 32'(m_credit));
        end
        check("mdl wt_rd_data", 32'(wt_rd_data), 32'(m_w[wt_rd_addr]));
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic wr_weight(input logic [2:0] a, input logic [6:0] d);
        wt_wr_en = 1'b1; wt_wr_addr = a; wt_wr_data = d;
        @(negedge clk);
        wt_wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
    endtask

    task automatic wait_grant(input string nm);
        int k;
        k = 0;
        while (!grant_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!grant_valid) check({nm, " timeout"}, 32'(grant_valid), 32'd1);
    endtask

    logic [7:0] exp_g [6] = '{8'h01, 8'h02, 8'h04, 8'h04, 8'h04, 8'h08};
    logic [6:0] exp_c [6] = '{7'd1, 7'd1, 7'd3, 7'd2, 7'd1, 7'd1};

    initial begin
        // reset values, no release yet
        #23;
        check("rst grant", 32'(grant), 32'h0);
        check("rst grant_valid", 32'(grant_valid), 32'h0);
        check("rst grant_idx", 32'(grant_idx), 32'h0);
        check("rst credit", 32'(credit), 32'h0);
        check("rst weight", 32'(wt_rd_data), 32'h1);

        // plain round robin with default weights
        @(negedge clk); reset = 1'b1; req = 8'hFF; out_rdy = 1'b1;
        @(negedge clk);
        check("A first grant", 32'(grant), 32'h01);
        check("A first credit", 32'(credit), 32'h1);
        pulse_done();
        check("A gap after turn", 32'(grant_valid), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            wait_grant("A grant");
            check("A rr grant", 32'(grant), 32'd1 << (k % 8));
            pulse_done();
        end

        // weight 3 on queue 2 holds the grant for three packets
        req = 8'h00; do_reset(); wr_weight(3'd2, 7'd3); req = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            if (i > 0 && exp_g[i] == exp_g[i-1])
                check("B held valid", 32'(grant_valid), 32'h1);
            else
                wait_grant("B grant");
            check("B grant", 32'(grant), 32'(exp_g[i]));
            check("B credit", 32'(credit), 32'(exp_c[i]));
            pulse_done();
        end

        // zero weight on queue 1 makes it ineligible
        req = 8'h00; do_reset(); wr_weight(3'd1, 7'd0);
        wt_rd_addr = 3'd1; #1;
        check("C rd weight1", 32'(wt_rd_data), 32'h0);
        req = 8'h03;
        for (int i = 0; i < 4; i++) begin
            wait_grant("C grant");
            check("C only q0", 32'(grant), 32'h01);
            pulse_done();
        end
        wt_rd_addr = 3'd2; #1;
        check("C rd weight2", 32'(wt_rd_data), 32'h1);

        // req drops mid-turn: grant held to pkt_done, then IDLE, then next queue
        req = 8'h00; do_reset(); wr_weight(3'd2, 7'd5); req = 8'h0C;
        wait_grant("D grant");
        check("D grant q2", 32'(grant), 32'h04);
        check("D credit", 32'(credit), 32'h5);
        req = 8'h08; out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("D held", 32'(grant), 32'h04);
        end
        out_rdy = 1'b1;
        pulse_done();
        check("D idle after done", 32'(grant_valid), 32'h0);
        out_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("D no grant w/o rdy", 32'(grant_valid), 32'h0);
        end
        out_rdy = 1'b1;
        wait_grant("D next");
        check("D next grant", 32'(grant), 32'h08);
        pulse_done();

        // asynchronous reset while busy on queue 4
        req = 8'h00; do_reset(); req = 8'h10;
        wait_grant("E grant");
        check("E grant q4", 32'(grant), 32'h10);
        #2 reset = 1'b0;
        #1;
        check("E async drop", 32'(grant), 32'h0);
        check("E async valid", 32'(grant_valid), 32'h0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("E regrant", 32'(grant), 32'h10);
        check("E credit", 32'(credit), 32'h1);
        pulse_done();

        // weight write mid-turn applies at the next turn; writing 0 ends the turn
        req = 8'h00; do_reset(); req = 8'h08;
        wait_grant("F grant");
        check("F credit1", 32'(credit), 32'h1);
        wr_weight(3'd3, 7'd7);
        check("F credit unchanged", 32'(credit), 32'h1);
        pulse_done();
        check("F turn ended", 32'(grant_valid), 32'h0);
        wait_grant("F regrant");
        check("F grant q3", 32'(grant), 32'h08);
        check("F credit7", 32'(credit), 32'h7);
        wr_weight(3'd3, 7'd0);
        pulse_done();
        check("F zero ends", 32'(grant_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("F zero never", 32'(grant_valid), 32'h0);
        end
        wt_rd_addr = 3'd3; #1;
        check("F rd weight3", 32'(wt_rd_data), 32'h0);

        req = 8'h00;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
